uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of the UART receiver.
- Captures each byte the receiver flags valid and holds it in a first-word-fall-through FIFO for a ready/valid consumer (CPU bridge or packet parser).
- Reports overrun and BREAK conditions as sticky status flags.
- Raises a character-timeout indication when bytes sit unread with no new arrivals, so software can drain partial messages.

Parameters:
- PAYLOAD_BITS, 8, width of one received byte; matches the receiver.
- DEPTH, 16, FIFO entries; power of two, >= 2.
- TIMEOUT_CYCLES, 200000, idle clocks before rx_timeout asserts (4 frames at 5000 clk/bit, 10 bits/frame).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- uart_rx_valid  in  1  one-cycle pulse per completed receiver frame.
- uart_rx_break  in  1  qualifies uart_rx_valid; frame was a BREAK (all-zero payload).
- uart_rx_data  in  PAYLOAD_BITS  received byte; valid in the cycle uart_rx_valid is high.
- rd_valid  out  1  FIFO non-empty; rd_data holds the oldest byte.
- rd_ready  in  1  consumer accepts rd_data this cycle.
- rd_data  out  PAYLOAD_BITS  head-of-FIFO byte.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overrun  out  1  sticky: a byte was dropped because the FIFO was full.
- break_seen  out  1  sticky: a BREAK frame was received.
- rx_timeout  out  1  FIFO non-empty and idle for TIMEOUT_CYCLES.
- clear_flags  in  1  one-cycle pulse; clears overrun and break_seen.

Behaviour:
- Reset (reset=1 at a clk edge):
  - read/write pointers, fifo_level, overrun, break_seen, rx_timeout and the idle counter all go to 0.
  - rd_valid=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored bytes; uart_rx_valid in the reset cycle is ignored.
- Push condition: uart_rx_valid & ~uart_rx_break & (fifo_level<DEPTH | pop).
  - Byte is stored at the write pointer; the pointer increments and wraps modulo DEPTH.
- Pop condition: rd_valid & rd_ready.
  - Read pointer increments and wraps modulo DEPTH.
  - rd_ready while empty has no effect.
- FWFT: rd_valid = (fifo_level!=0); rd_data is the entry at the read pointer, with no read latency.
- Write-to-read latency: a byte pushed at edge N makes rd_valid/rd_data visible after edge N, i.e. 1 cycle.
- fifo_level update at each edge:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on push and pop together, or on neither.
- Full with simultaneous pop: the incoming byte is accepted; level stays DEPTH; no overrun.
- Full without pop: the incoming byte is dropped, FIFO contents are unchanged, and overrun is set the next cycle.
- BREAK (uart_rx_valid & uart_rx_break): no byte is written, regardless of level; break_seen is set.
- Sticky flags hold until clear_flags or reset.
  - If clear_flags and a set event occur in the same cycle, the set wins and the flag stays 1.
- Idle counter (width $clog2(TIMEOUT_CYCLES+1)):
  - Cleared to 0 on push, on pop, or while the FIFO is empty.
  - Otherwise increments, saturating at TIMEOUT_CYCLES.
- rx_timeout = (idle counter == TIMEOUT_CYCLES), registered.
  - Deasserts the cycle after any push or pop, or when the FIFO is empty.
  - BREAK frames and dropped bytes do not reset the counter.
- Pointers are log2(DEPTH) bits; full vs empty is distinguished by fifo_level, not by pointer equality alone.
- No X on any output after reset; rd_data is don't-care while rd_valid=0.

Test Plan:
Bench overrides DEPTH=4 and TIMEOUT_CYCLES=50.
1. Reset, then push 0x41, 0x42, 0x43 with rd_ready=0 -> rd_valid=1 one cycle after the first push, rd_data=0x41, fifo_level=3; then rd_ready=1 for 3 cycles -> reads 0x41, 0x42, 0x43 in order; fifo_level=0, rd_valid=0.
2. Push 5 bytes 0x01..0x05 with rd_ready=0 -> fifo_level=4, overrun=1 after the 5th; drained data is 0x01..0x04; clear_flags pulse -> overrun=0.
3. FIFO full (4 entries) with uart_rx_valid and rd_ready in the same cycle -> new byte accepted, fifo_level stays 4, overrun=0; wrap-around order is preserved over 12 continuous push/pop cycles.
4. uart_rx_valid with uart_rx_break=1, data=0x00 -> fifo_level unchanged, break_seen=1; clear_flags in the same cycle as a second BREAK -> break_seen stays 1.
5. Push one byte then idle -> rx_timeout=1 exactly 50 cycles after the push; a pop clears it next cycle; with the FIFO empty, no timeout ever asserts.
6. Three bytes stored, reset asserted for one cycle mid-stream -> fifo_level=0, rd_valid=0, flags 0; the next push of 0x5A reads back 0x5A.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive-side buffer between a UART receiver and a ready/valid consumer.
// Valid non-BREAK bytes from the receiver go into a first-word-fall-through
// FIFO. Overrun (byte dropped while full) and BREAK reception are reported as
// sticky flags. A character-timeout flag rises when bytes sit unread with no
// push or pop activity for TIMEOUT_CYCLES clocks.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-high reset
//   uart_rx_valid  one-cycle pulse per completed receiver frame
//   uart_rx_break  qualifies uart_rx_valid: frame was a BREAK
//   uart_rx_data   received byte, valid with uart_rx_valid
//   rd_valid       FIFO non-empty, rd_data holds the oldest byte
//   rd_ready       consumer accepts rd_data this cycle
//   rd_data        head-of-FIFO byte (no read latency)
//   fifo_level     occupancy 0..DEPTH
//   overrun        sticky: byte dropped because FIFO was full
//   break_seen     sticky: BREAK frame received
//   rx_timeout     FIFO non-empty and idle for TIMEOUT_CYCLES
//   clear_flags    one-cycle pulse clearing overrun and break_seen
module uart_rx_fifo #(
  parameter int PAYLOAD_BITS   = 8,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       uart_rx_valid,
  input  logic                       uart_rx_break,
  input  logic [PAYLOAD_BITS-1:0]    uart_rx_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [PAYLOAD_BITS-1:0]    rd_data,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overrun,
  output logic                       break_seen,
  output logic                       rx_timeout,
  input  logic                       clear_flags
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic             overrun_q, overrun_d;
  logic             break_q, break_d;
  logic             timeout_q, timeout_d;

  logic accept, push, pop, drop;

  always_comb begin
    pop    = (level_q != '0) & rd_ready;
    accept = uart_rx_valid & ~uart_rx_break;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push   = accept & ((level_q != LVL_FULL) | pop);
    drop   = accept & ~push;

    wptr_d = push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + PTR_W'(1) : rptr_q;

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // Set events take priority over a simultaneous clear.
    overrun_d = drop | (overrun_q & ~clear_flags);
    break_d   = (uart_rx_valid & uart_rx_break) | (break_q & ~clear_flags);

    // Only real FIFO traffic restarts the idle count; BREAKs and drops do not.
    if (push | pop | (level_q == '0)) begin
      idle_d = '0;
    end else if (idle_q != IDLE_MAX) begin
      idle_d = idle_q + CNT_W'(1);
    end else begin
      idle_d = idle_q;
    end
    timeout_d = (idle_d == IDLE_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      idle_q    <= '0;
      overrun_q <= 1'b0;
      break_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      idle_q    <= idle_d;
      overrun_q <= overrun_d;
      break_q   <= break_d;
      timeout_q <= timeout_d;
    end
  end

  // Storage is deliberately not reset; the write is suppressed during reset.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wptr_q] <= uart_rx_data;
    end
  end

  assign rd_valid   = (level_q != '0);
  assign rd_data    = mem_q[rptr_q];
  assign fifo_level = level_q;
  assign overrun    = overrun_q;
  assign break_seen = break_q;
  assign rx_timeout = timeout_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
// Self-checking bench for uart_rx_fifo with DEPTH=4, TIMEOUT_CYCLES=50.
// A queue-based reference model tracks FIFO contents, sticky flags and the
// edge of the last FIFO activity; every cycle the DUT outputs are compared.
module tb_uart_rx_fifo;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int TMO   = 50;

  logic         clk = 1'b0;
  logic         reset;
  logic         uart_rx_valid;
  logic         uart_rx_break;
  logic [W-1:0] uart_rx_data;
  logic         rd_valid;
  logic         rd_ready;
  logic [W-1:0] rd_data;
  logic [2:0]   fifo_level;
  logic         overrun;
  logic         break_seen;
  logic         rx_timeout;
  logic         clear_flags;

  int checkCount = 0;
  int failCount  = 0;

  // Reference model state.
  logic [W-1:0] modelQ[$];
  bit           modelOvr;
  bit           modelBrk;
  int           edgeNo;
  int           lastEvt;

  uart_rx_fifo #(
    .PAYLOAD_BITS   (W),
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_break (uart_rx_break),
    .uart_rx_data  (uart_rx_data),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_data       (rd_data),
    .fifo_level    (fifo_level),
    .overrun       (overrun),
    .break_seen    (break_seen),
    .rx_timeout    (rx_timeout),
    .clear_flags   (clear_flags)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at edge %0d",
               tag, actual, expected, edgeNo);
    end
  endtask

  task automatic checkAll();
    bit expTimeout;
    expTimeout = (modelQ.size() != 0) && ((edgeNo - lastEvt) >= TMO);
    checkOutput("rd_valid", rd_valid, modelQ.size() != 0);
    checkOutput("fifo_level", fifo_level, modelQ.size());
    if (modelQ.size() != 0) checkOutput("rd_data", rd_data, modelQ[0]);
    checkOutput("overrun", overrun, modelOvr);
    checkOutput("break_seen", break_seen, modelBrk);
    checkOutput("rx_timeout", rx_timeout, expTimeout);
  endtask

  // Drive one cycle of inputs, advance the model by one edge, then check.
  task automatic applyStimulus(input bit v, input bit b, input logic [W-1:0] d,
                               input bit r, input bit c);
    int preSize;
    bit doPop, doPush, doDrop;
    logic [W-1:0] dummy;
    uart_rx_valid = v;
    uart_rx_break = b;
    uart_rx_data  = d;
    rd_ready      = r;
    clear_flags   = c;
    preSize = modelQ.size();
    doPop   = (preSize > 0) && r;
    doPush  = v && !b && ((preSize < DEPTH) || doPop);
    doDrop  = v && !b && !doPush;
    @(posedge clk);
    #1;
    edgeNo++;
    if (doPop) dummy = modelQ.pop_front();
    if (doPush) modelQ.push_back(d);
    modelOvr = doDrop || (modelOvr && !c);
    modelBrk = (v && b) || (modelBrk && !c);
    if (doPush || doPop || preSize == 0) lastEvt = edgeNo;
    checkAll();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 8'h00, 0, 0);
  endtask

  // Reset for one edge with a valid byte offered, which must be ignored.
  task automatic doReset();
    reset         = 1'b1;
    uart_rx_valid = 1'b1;
    uart_rx_break = 1'b0;
    uart_rx_data  = 8'hEE;
    rd_ready      = 1'b0;
    clear_flags   = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    edgeNo++;
    modelQ.delete();
    modelOvr = 0;
    modelBrk = 0;
    lastEvt  = edgeNo;
    uart_rx_valid = 1'b0;
    checkAll();
  endtask

  initial begin
    edgeNo  = 0;
    lastEvt = 0;
    doReset();
    checkOutput("reset_level", fifo_level, 0);
    checkOutput("reset_valid", rd_valid, 0);

    // 1: three pushes, FWFT head visible after the first, then drain in order.
    $display("[TB] scenario 1: basic push/pop");
    applyStimulus(1, 0, 8'h41, 0, 0);
    checkOutput("t1_first_valid", rd_valid, 1);
    checkOutput("t1_first_head", rd_data, 8'h41);
    applyStimulus(1, 0, 8'h42, 0, 0);
    applyStimulus(1, 0, 8'h43, 0, 0);
    checkOutput("t1_level3", fifo_level, 3);
    applyStimulus(0, 0, 8'h00, 1, 0);
    checkOutput("t1_head2", rd_data, 8'h42);
    applyStimulus(0, 0, 8'h00, 1, 0);
    checkOutput("t1_head3", rd_data, 8'h43);
    applyStimulus(0, 0, 8'h00, 1, 0);
    checkOutput("t1_empty", rd_valid, 0);
    applyStimulus(0, 0, 8'h00, 1, 0);

    // 2: overfill, drain, clear overrun.
    $display("[TB] scenario 2: overrun");
    for (int i = 1; i <= 5; i++) applyStimulus(1, 0, 8'(i), 0, 0);
    checkOutput("t2_level_full", fifo_level, 4);
    checkOutput("t2_overrun", overrun, 1);
    applyStimulus(1, 0, 8'h99, 0, 1);
    checkOutput("t2_set_beats_clear", overrun, 1);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("t2_drain", rd_data, 8'(i));
      applyStimulus(0, 0, 8'h00, 1, 0);
    end
    applyStimulus(0, 0, 8'h00, 0, 1);
    checkOutput("t2_cleared", overrun, 0);

    // 3: full FIFO with concurrent push/pop for 12 cycles (wraps pointers).
    $display("[TB] scenario 3: full with simultaneous pop");
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 8'h10 + 8'(i), 0, 0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 0, 8'h20 + 8'(i), 1, 0);
      checkOutput("t3_level", fifo_level, 4);
      checkOutput("t3_no_overrun", overrun, 0);
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 8'h00, 1, 0);

    // 4: BREAK frames do not store data; set beats clear.
    $display("[TB] scenario 4: break");
    applyStimulus(1, 0, 8'h77, 0, 0);
    applyStimulus(1, 1, 8'h00, 0, 0);
    checkOutput("t4_level", fifo_level, 1);
    checkOutput("t4_break", break_seen, 1);
    applyStimulus(1, 1, 8'h00, 0, 1);
    checkOutput("t4_break_hold", break_seen, 1);
    applyStimulus(0, 0, 8'h00, 1, 1);
    checkOutput("t4_break_clr", break_seen, 0);

    // 5: timeout exactly TMO cycles after a push; cleared by pop.
    $display("[TB] scenario 5: timeout");
    applyStimulus(1, 0, 8'h33, 0, 0);
    idleCycles(TMO - 1);
    checkOutput("t5_before", rx_timeout, 0);
    applyStimulus(0, 1, 8'h00, 0, 0);
    checkOutput("t5_timeout", rx_timeout, 1);
    idleCycles(3);
    applyStimulus(0, 0, 8'h00, 1, 0);
    checkOutput("t5_popclr", rx_timeout, 0);
    idleCycles(TMO + 10);
    checkOutput("t5_empty_no_to", rx_timeout, 0);

    // 6: reset mid-stream discards contents and flags.
    $display("[TB] scenario 6: reset mid-stream");
    applyStimulus(1, 0, 8'hA1, 0, 0);
    applyStimulus(1, 0, 8'hA2, 0, 0);
    applyStimulus(1, 1, 8'h00, 0, 0);
    applyStimulus(1, 0, 8'hA3, 0, 0);
    doReset();
    checkOutput("t6_level", fifo_level, 0);
    checkOutput("t6_flags", {overrun, break_seen, rx_timeout}, 0);
    applyStimulus(1, 0, 8'h5A, 0, 0);
    checkOutput("t6_data", rd_data, 8'h5A);
    applyStimulus(0, 0, 8'h00, 1, 0);

    // Random traffic with varying consumer pressure.
    $display("[TB] random phase");
    for (int i = 0; i < 600; i++) begin
      bit v, b, r, c;
      int readBias;
      readBias = (i / 100) % 3;
      v = ($urandom_range(0, 2) != 0);
      b = ($urandom_range(0, 11) == 0);
      r = ($urandom_range(0, 3) < readBias + 1);
      c = ($urandom_range(0, 15) == 0);
      applyStimulus(v, b, 8'($urandom), r, c);
      if ($urandom_range(0, 49) == 0) idleCycles($urandom_range(1, TMO + 5));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checkCount, failCount);
    $finish;
  end

endmodule
